pwm_capture: RTL and testbench

- Decodes a single PWM waveform produced by the team's PWM generator: measures high time and period in clk_in cycles.
- Reports each completed measurement with a one-cycle valid strobe.
- Detects a static input (0 % / 100 % duty, or a dead line) by timeout.
- Sits on the receive side of a PWM link; pwm_in is asynchronous to clk_in.

---
 rtl/pwm_pkg.sv | 17 +
 rtl/pwm_sync.sv | 20 ++
 rtl/pwm_capture.sv | 118 +++++++++++
 tb/tb_pwm_capture.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the PWM capture block
package pwm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STUCK   = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 6;
  localparam int MAX_DEF   = (1 << CNT_W_DEF) - 1;

  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/pwm_sync.sv
// rtl/pwm_sync.sv - multi-flop synchroniser for the asynchronous PWM input
module pwm_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic din,
  output logic s
);

  logic [SYNC_STAGES-1:0] chain;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) chain <= '0;
    else     chain <= {chain[SYNC_STAGES-2:0], din};
  end

  assign s = chain[SYNC_STAGES-1];

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures PWM high time and period, flags a static line
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             en,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] duty_out,
  output logic [CNT_W-1:0] period_out,
  output logic             valid,
  output logic             stuck,
  output logic             level_out
);

  localparam logic [CNT_W-1:0] MAX = CNT_W'(cnt_max(CNT_W));

  logic             s;
  logic             s_prev;
  logic             rise;
  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] period_cnt;
  logic [CNT_W-1:0] high_cnt;
  logic [CNT_W-1:0] duty_d;
  logic [CNT_W-1:0] period_d;
  logic             valid_d;
  logic             stuck_d;

  pwm_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .din    (pwm_in),
    .s      (s)
  );

  assign rise      = s & ~s_prev;
  assign level_out = s;

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) s_prev <= 1'b0;
    else     s_prev <= s;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A rise always wins over saturation, so a period of exactly MAX is still reported.
  always_comb begin
    next_state = state;
    if (!en)
      next_state = IDLE;
    else if (rise)
      next_state = MEASURE;
    else if (state != STUCK && period_cnt == MAX)
      next_state = STUCK;
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (!en) begin
      period_cnt <= '0;
      high_cnt   <= '0;
    end else if (rise) begin
      period_cnt <= CNT_W'(1);
      high_cnt   <= CNT_W'(1);
    end else begin
      if (period_cnt != MAX)
        period_cnt <= period_cnt + 1'b1;
      if (state == MEASURE && s && high_cnt != MAX)
        high_cnt <= high_cnt + 1'b1;
    end
  end

  // The first rise after IDLE or STUCK only starts a period; it never reports one.
  always_comb begin
    duty_d   = duty_out;
    period_d = period_out;
    stuck_d  = stuck;
    valid_d  = 1'b0;
    if (en) begin
      if (next_state == STUCK) begin
        stuck_d  = 1'b1;
        period_d = '0;
        duty_d   = s ? MAX : '0;
      end else if (rise) begin
        stuck_d = 1'b0;
        if (state == MEASURE) begin
          valid_d  = 1'b1;
          duty_d   = high_cnt;
          period_d = period_cnt;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      duty_out   <= '0;
      period_out <= '0;
      valid      <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      duty_out   <= duty_d;
      period_out <= period_d;
      valid      <= valid_d;
      stuck      <= stuck_d;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - directed self-checking bench for pwm_capture
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       pwm_in;
  logic [5:0] duty_out;
  logic [5:0] period_out;
  logic       valid;
  logic       stuck;
  logic       level_out;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int vcount = 0;
  int last_vcyc = 0;
  int last_duty = 0;
  int last_period = 0;

  int gen_duty = 0;
  int gen_per = 32;
  int gen_phase = 0;
  bit gen_restart = 1'b0;

  pwm_capture dut (
    .clk_in     (clk),
    .rst        (rst),
    .en         (en),
    .pwm_in     (pwm_in),
    .duty_out   (duty_out),
    .period_out (period_out),
    .valid      (valid),
    .stuck      (stuck),
    .level_out  (level_out)
  );

  always #5 clk = ~clk;

  // PWM generator: one frame of gen_per cycles, high for the first gen_duty.
  initial begin
    pwm_in = 1'b0;
    forever begin
      @(negedge clk);
      if (gen_restart) begin
        gen_phase   = 0;
        gen_restart = 1'b0;
      end
      pwm_in    = (gen_phase < gen_duty);
      gen_phase = (gen_phase + 1) % gen_per;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (valid === 1'b1) begin
        vcount++;
        last_vcyc   = cyc;
        last_duty   = duty_out;
        last_period = period_out;
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    gen_restart = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (vcount >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (duty_out !== 6'd0)   begin n_fail++; $display("FAIL reset_duty: got %0d want 0", duty_out); end
    n_cmp++; if (period_out !== 6'd0) begin n_fail++; $display("FAIL reset_period: got %0d want 0", period_out); end
    n_cmp++; if (valid !== 1'b0)      begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid); end
    n_cmp++; if (stuck !== 1'b0)      begin n_fail++; $display("FAIL reset_stuck: got %0b want 0", stuck); end
    n_cmp++; if (level_out !== 1'b0)  begin n_fail++; $display("FAIL reset_level: got %0b want 0", level_out); end
  endtask

  task automatic test_duty8();
    bit ok;
    int start, base, prev;
    gen_per  = 32;
    gen_duty = 8;
    do_reset();
    start = cyc;
    base  = vcount;
    wait_valid(base + 1, 100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL d8_first_timeout: got none want 1 valid"); end
    n_cmp++; if (last_vcyc - start !== 35) begin n_fail++; $display("FAIL d8_first_latency: got %0d want 35", last_vcyc - start); end
    for (int k = 0; k < 3; k++) begin
      prev = last_vcyc;
      wait_valid(base + 2 + k, 80, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL d8_timeout: got none want valid %0d", k); end
      n_cmp++; if (last_vcyc - prev !== 32) begin n_fail++; $display("FAIL d8_spacing: got %0d want 32", last_vcyc - prev); end
      n_cmp++; if (last_duty !== 8)    begin n_fail++; $display("FAIL d8_duty: got %0d want 8", last_duty); end
      n_cmp++; if (last_period !== 32) begin n_fail++; $display("FAIL d8_period: got %0d want 32", last_period); end
      n_cmp++; if (stuck !== 1'b0)     begin n_fail++; $display("FAIL d8_stuck: got %0b want 0", stuck); end
    end
  endtask

  task automatic test_stuck_low();
    bit ok;
    int base, c0;
    gen_per  = 32;
    gen_duty = 0;
    do_reset();
    base = vcount;
    repeat (60) @(negedge clk);
    n_cmp++; if (stuck !== 1'b0) begin n_fail++; $display("FAIL low_stuck_early: got %0b want 0", stuck); end
    repeat (10) @(negedge clk);
    n_cmp++; if (stuck !== 1'b1)      begin n_fail++; $display("FAIL low_stuck: got %0b want 1", stuck); end
    n_cmp++; if (duty_out !== 6'd0)   begin n_fail++; $display("FAIL low_duty: got %0d want 0", duty_out); end
    n_cmp++; if (period_out !== 6'd0) begin n_fail++; $display("FAIL low_period: got %0d want 0", period_out); end
    n_cmp++; if (vcount !== base)     begin n_fail++; $display("FAIL low_novalid: got %0d want %0d", vcount, base); end
    gen_duty    = 5;
    gen_restart = 1'b1;
    @(negedge clk);
    c0 = cyc;
    repeat (4) @(negedge clk);
    n_cmp++; if (stuck !== 1'b0) begin n_fail++; $display("FAIL low_unstuck: got %0b want 0", stuck); end
    wait_valid(base + 1, 80, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL low_d5_timeout: got none want 1 valid"); end
    n_cmp++; if (last_vcyc - c0 !== 35) begin n_fail++; $display("FAIL low_d5_latency: got %0d want 35", last_vcyc - c0); end
    n_cmp++; if (last_duty !== 5)       begin n_fail++; $display("FAIL low_d5_duty: got %0d want 5", last_duty); end
    n_cmp++; if (last_period !== 32)    begin n_fail++; $display("FAIL low_d5_period: got %0d want 32", last_period); end
  endtask

  task automatic test_stuck_high();
    int base;
    gen_per  = 32;
    gen_duty = 32;
    do_reset();
    base = vcount;
    repeat (80) @(negedge clk);
    n_cmp++; if (stuck !== 1'b1)      begin n_fail++; $display("FAIL high_stuck: got %0b want 1", stuck); end
    n_cmp++; if (duty_out !== 6'd63)  begin n_fail++; $display("FAIL high_duty: got %0d want 63", duty_out); end
    n_cmp++; if (period_out !== 6'd0) begin n_fail++; $display("FAIL high_period: got %0d want 0", period_out); end
    n_cmp++; if (level_out !== 1'b1)  begin n_fail++; $display("FAIL high_level: got %0b want 1", level_out); end
    n_cmp++; if (vcount !== base)     begin n_fail++; $display("FAIL high_novalid: got %0d want %0d", vcount, base); end
  endtask

  task automatic test_glitch();
    bit ok;
    int base;
    gen_per  = 32;
    gen_duty = 1;
    do_reset();
    base = vcount;
    wait_valid(base + 2, 120, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL glitch_timeout: got none want 2 valids"); end
    n_cmp++; if (last_duty !== 1)    begin n_fail++; $display("FAIL glitch_duty: got %0d want 1", last_duty); end
    n_cmp++; if (last_period !== 32) begin n_fail++; $display("FAIL glitch_period: got %0d want 32", last_period); end
  endtask

  task automatic test_period_max();
    bit ok;
    int base;
    gen_per  = 63;
    gen_duty = 10;
    do_reset();
    base = vcount;
    wait_valid(base + 2, 200, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL pmax_timeout: got none want 2 valids"); end
    n_cmp++; if (last_duty !== 10)   begin n_fail++; $display("FAIL pmax_duty: got %0d want 10", last_duty); end
    n_cmp++; if (last_period !== 63) begin n_fail++; $display("FAIL pmax_period: got %0d want 63", last_period); end
    n_cmp++; if (stuck !== 1'b0)     begin n_fail++; $display("FAIL pmax_stuck: got %0b want 0", stuck); end
    gen_per = 32;
  endtask

  task automatic test_duty_change();
    bit ok;
    int base;
    gen_per  = 32;
    gen_duty = 8;
    do_reset();
    base = vcount;
    wait_valid(base + 1, 100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL chg_first_timeout: got none want 1 valid"); end
    repeat (20) @(negedge clk);
    gen_duty = 20;
    base = vcount;
    wait_valid(base + 1, 80, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL chg_trans_timeout: got none want 1 valid"); end
    for (int k = 0; k < 3; k++) begin
      wait_valid(base + 2 + k, 80, ok);
      n_cmp++; if (!ok) begin n_fail++; $display("FAIL chg_timeout: got none want valid %0d", k); end
      n_cmp++; if (last_duty !== 20)   begin n_fail++; $display("FAIL chg_duty: got %0d want 20", last_duty); end
      n_cmp++; if (last_period !== 32) begin n_fail++; $display("FAIL chg_period: got %0d want 32", last_period); end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int base, start;
    gen_per  = 32;
    gen_duty = 8;
    do_reset();
    base = vcount;
    wait_valid(base + 2, 120, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL arst_pre_timeout: got none want 2 valids"); end
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (duty_out !== 6'd0)   begin n_fail++; $display("FAIL arst_duty: got %0d want 0", duty_out); end
    n_cmp++; if (period_out !== 6'd0) begin n_fail++; $display("FAIL arst_period: got %0d want 0", period_out); end
    n_cmp++; if (valid !== 1'b0)      begin n_fail++; $display("FAIL arst_valid: got %0b want 0", valid); end
    n_cmp++; if (stuck !== 1'b0)      begin n_fail++; $display("FAIL arst_stuck: got %0b want 0", stuck); end
    @(negedge clk);
    repeat (2) @(negedge clk);
    rst   = 1'b0;
    start = cyc;
    base  = vcount;
    wait_valid(base + 1, 120, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL arst_post_timeout: got none want 1 valid"); end
    n_cmp++; if (last_vcyc - start < 49 || last_vcyc - start > 55)
      begin n_fail++; $display("FAIL arst_latency: got %0d want 49..55", last_vcyc - start); end
    n_cmp++; if (last_duty !== 8)    begin n_fail++; $display("FAIL arst_duty_after: got %0d want 8", last_duty); end
    n_cmp++; if (last_period !== 32) begin n_fail++; $display("FAIL arst_period_after: got %0d want 32", last_period); end
  endtask

  task automatic test_enable();
    bit ok;
    int base, start;
    gen_per  = 32;
    gen_duty = 8;
    do_reset();
    base = vcount;
    wait_valid(base + 1, 100, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL en_pre_timeout: got none want 1 valid"); end
    repeat (10) @(negedge clk);
    en   = 1'b0;
    base = vcount;
    repeat (5) @(negedge clk);
    n_cmp++; if (duty_out !== 6'd8)    begin n_fail++; $display("FAIL en_hold_duty: got %0d want 8", duty_out); end
    n_cmp++; if (period_out !== 6'd32) begin n_fail++; $display("FAIL en_hold_period: got %0d want 32", period_out); end
    n_cmp++; if (vcount !== base)      begin n_fail++; $display("FAIL en_novalid: got %0d want %0d", vcount, base); end
    en    = 1'b1;
    start = cyc;
    wait_valid(base + 1, 120, ok);
    n_cmp++; if (!ok) begin n_fail++; $display("FAIL en_post_timeout: got none want 1 valid"); end
    n_cmp++; if (last_vcyc - start < 46 || last_vcyc - start > 52)
      begin n_fail++; $display("FAIL en_latency: got %0d want 46..52", last_vcyc - start); end
    n_cmp++; if (last_duty !== 8)    begin n_fail++; $display("FAIL en_duty: got %0d want 8", last_duty); end
    n_cmp++; if (last_period !== 32) begin n_fail++; $display("FAIL en_period: got %0d want 32", last_period); end
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b1;
    test_reset();
    test_duty8();
    test_stuck_low();
    test_stuck_high();
    test_glitch();
    test_period_max();
    test_duty_change();
    test_async_reset();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
